// File: rtl/seg_pkg.sv
// seg_pkg
// Shared constants for the seven-segment display scanner:
//   DIGITS  - number of multiplexed digits
//   SEG_OFF - active-low segment pattern with every segment dark
//   AN_OFF  - active-low anode pattern with every digit deselected
//   HEX_SEG - hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
package seg_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Listed from entry F down to entry 0 so that HEX_SEG[n] is the pattern for n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg.sv
// hex7seg
// Purely combinational hex digit decoder.
// Ports:
//   hex   - 4-bit digit value
//   seg_n - active-low segments {g,f,e,d,c,b,a}
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
// Time-multiplexes a 16-bit hex value onto four common-anode seven-segment
// digits. Each digit owns a slot of DIV cycles; the first GAP cycles of every
// slot are dead time with all anodes off to avoid ghosting.
//
// A new value is offered with load; it is held in a pending register and only
// copied into the display register on the wrap from digit 3 to digit 0, so a
// scan never shows a mix of old and new digits.
//
// Handshake: a transfer happens on a rising clk edge where load=1 and ready=1;
// value/dp_in/blank_lz are captured at that edge. ready is low while an update
// is pending and returns high in the cycle after the pending value reaches the
// display register. load while ready=0 is ignored.
//
// Ports:
//   clk      - clock, rising edge
//   btn      - asynchronous active-high reset
//   value    - hex value, nibble i shows on digit i (digit 0 rightmost)
//   load     - update request strobe
//   ready    - high when a new value can be accepted
//   dp_in    - decimal-point enable per digit
//   blank_lz - leading-zero suppression enable
//   seg      - active-low segments {g,f,e,d,c,b,a} (registered)
//   dp_n     - active-low decimal point (registered)
//   an       - active-low anodes, an[i] selects digit i (registered)
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int GAP = 1000
) (
    input  logic        clk,
    input  logic        btn,
    input  logic [15:0] value,
    input  logic        load,
    output logic        ready,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);

    // Scan state
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    // Display and pending registers
    logic [15:0] disp_val;
    logic [3:0]  disp_dp;
    logic        disp_lz;
    logic [15:0] pend_val;
    logic [3:0]  pend_dp;
    logic        pend_lz;
    logic        pend_valid;

    logic       slot_wrap;
    logic       scan_wrap;
    logic       accept;
    logic       transfer;
    logic       in_gap;
    logic       blank_digit;
    logic [3:0] cur_nib;
    logic [6:0] dec_seg;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_n_nxt;

    assign ready     = ~pend_valid;
    assign slot_wrap = (cnt == CNT_LAST);
    assign scan_wrap = slot_wrap && (idx == 2'd3);
    assign accept    = load && ready;
    // accept and transfer never coincide: accept needs pend_valid=0.
    assign transfer  = scan_wrap && pend_valid;
    assign in_gap    = (cnt < CNT_GAP);
    assign cur_nib   = disp_val[4*idx +: 4];

    // A digit is a leading zero when it and every higher nibble are zero.
    // Digit 0 always shows so that a value of 0 still lights something.
    always_comb begin
        blank_digit = 1'b0;
        if (disp_lz) begin
            case (idx)
                2'd3:    blank_digit = (disp_val[15:12] == 4'h0);
                2'd2:    blank_digit = (disp_val[15:8]  == 8'h00);
                2'd1:    blank_digit = (disp_val[15:4]  == 12'h000);
                default: blank_digit = 1'b0;
            endcase
        end
    end

    hex7seg u_hex7seg (
        .hex   (cur_nib),
        .seg_n (dec_seg)
    );

    always_comb begin
        an_nxt   = AN_OFF;
        seg_nxt  = SEG_OFF;
        dp_n_nxt = 1'b1;
        if (!in_gap) begin
            an_nxt   = ~(4'b0001 << idx);
            seg_nxt  = blank_digit ? SEG_OFF : dec_seg;
            // Blanking hides the digit but not its decimal point.
            dp_n_nxt = ~disp_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge btn) begin
        if (btn) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            disp_lz    <= 1'b0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
        end else begin
            if (slot_wrap) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (transfer) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                disp_lz    <= pend_lz;
                pend_valid <= 1'b0;
            end

            if (accept) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_lz    <= blank_lz;
                pend_valid <= 1'b1;
            end

            // Outputs trail the scan state by one cycle.
            an   <= an_nxt;
            seg  <= seg_nxt;
            dp_n <= dp_n_nxt;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;

  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int ACTIVE = DIV - GAP;

  logic        clk;
  logic        btn;
  logic [15:0] value;
  logic        load;
  logic        ready;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int total_cnt;
  int bad_cnt;

  // expected digit slot: {an[3:0], seg[6:0], dp_n}
  logic [11:0] exp_q[$];

  seg_display_scanner #(.DIV(DIV), .GAP(GAP)) dut (
    .clk      (clk),
    .btn      (btn),
    .value    (value),
    .load     (load),
    .ready    (ready),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp_n     (dp_n),
    .an       (an)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: ref_seg = 7'h40;  4'h1: ref_seg = 7'h79;
      4'h2: ref_seg = 7'h24;  4'h3: ref_seg = 7'h30;
      4'h4: ref_seg = 7'h19;  4'h5: ref_seg = 7'h12;
      4'h6: ref_seg = 7'h02;  4'h7: ref_seg = 7'h78;
      4'h8: ref_seg = 7'h00;  4'h9: ref_seg = 7'h10;
      4'hA: ref_seg = 7'h08;  4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46;  4'hD: ref_seg = 7'h21;
      4'hE: ref_seg = 7'h06;  default: ref_seg = 7'h0E;
    endcase
  endfunction

  // push the four expected slots of one scan (digit 0 first)
  task automatic push_scan(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic [15:0] upper;
    for (int i = 0; i < 4; i++) begin
      an_e  = 4'hF;
      an_e[i] = 1'b0;
      upper = v >> (4 * i);
      if (lz && i > 0 && upper == 16'h0000) seg_e = 7'h7F;
      else seg_e = ref_seg(upper[3:0]);
      exp_q.push_back({an_e, seg_e, ~dp[i]});
    end
  endtask

  // driver tasks
  task automatic drive_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    @(negedge clk);
    value    = v;
    dp_in    = dp;
    blank_lz = lz;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {15'd0, ready}, 16'd1);
  endtask

  // monitor: capture one full scan and compare each slot against exp_q
  task automatic capture_scan(input string tag);
    logic [11:0] exp_e;
    logic [11:0] got_e;
    int n;
    int width;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (an !== 4'hF && n < 40) begin
        @(negedge clk);
        n++;
      end
      while (an === 4'hF && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        check_val({tag, "_timeout"}, 16'd0, 16'd1);
        return;
      end
      got_e = {an, seg, dp_n};
      width = 0;
      while (an === got_e[11:8] && width < 40) begin
        width++;
        @(negedge clk);
      end
      if (exp_q.size() == 0) begin
        check_val({tag, "_q_empty"}, 16'd0, 16'd1);
      end else begin
        exp_e = exp_q.pop_front();
        check_val($sformatf("%s_slot%0d", tag, s), {4'd0, got_e}, {4'd0, exp_e});
      end
      check_val($sformatf("%s_width%0d", tag, s), 16'(width), 16'(ACTIVE));
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    btn       = 1'b1;
    value     = 16'h0000;
    load      = 1'b0;
    dp_in     = 4'h0;
    blank_lz  = 1'b0;

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_an",    {12'd0, an},   16'h000F);
    check_val("rst_seg",   {9'd0, seg},   16'h007F);
    check_val("rst_dp_n",  {15'd0, dp_n}, 16'd1);
    check_val("rst_ready", {15'd0, ready}, 16'd1);
    btn = 1'b0;
    check_val("rel_an0", {12'd0, an}, 16'h000F);
    @(negedge clk);
    check_val("rel_an1", {12'd0, an}, 16'h000F);
    @(negedge clk);
    check_val("rel_an2", {12'd0, an}, 16'h000F);
    @(negedge clk);
    check_val("rel_an3", {12'd0, an}, 16'h000E);
    check_val("rel_seg3", {9'd0, seg}, 16'h0040);

    // plain value
    drive_load(16'h1234, 4'b0000, 1'b0);
    push_scan(16'h1234, 4'b0000, 1'b0);
    @(negedge clk);
    check_val("v1234_busy", {15'd0, ready}, 16'd0);
    wait_ready("v1234_ready");
    capture_scan("v1234");

    // leading-zero blanking with decimal point on digit 1
    drive_load(16'h0050, 4'b0010, 1'b1);
    push_scan(16'h0050, 4'b0010, 1'b1);
    wait_ready("v0050_ready");
    capture_scan("v0050");

    // all-zero value with blanking: only digit 0 lit
    drive_load(16'h0000, 4'b0000, 1'b1);
    push_scan(16'h0000, 4'b0000, 1'b1);
    wait_ready("v0000_ready");
    capture_scan("v0000");

    // random values
    for (int r = 0; r < 3; r++) begin
      logic [15:0] rv;
      logic [3:0]  rd;
      logic        rl;
      rv = 16'($urandom_range(0, 16'hFFFF));
      rd = 4'($urandom_range(0, 15));
      rl = 1'($urandom_range(0, 1));
      if (r == 0) rv = rv & 16'h00FF;
      drive_load(rv, rd, rl);
      push_scan(rv, rd, rl);
      wait_ready($sformatf("rnd%0d_ready", r));
      capture_scan($sformatf("rnd%0d", r));
    end

    // second load while busy is ignored
    drive_load(16'hAAAA, 4'b0000, 1'b0);
    push_scan(16'hAAAA, 4'b0000, 1'b0);
    drive_load(16'hBBBB, 4'b1111, 1'b0);
    wait_ready("ignore_ready");
    capture_scan("ignore");

    // reset discards a pending update
    drive_load(16'hFFFF, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    check_val("midrst_ready", {15'd0, ready}, 16'd1);
    push_scan(16'h0000, 4'b0000, 1'b0);
    capture_scan("midrst");

    // load coinciding with the digit 3 -> 0 wrap waits a whole scan
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (4 * DIV - 1) @(posedge clk);
    drive_load(16'h9876, 4'b1001, 1'b0);
    @(negedge clk);
    check_val("wrapload_busy0", {15'd0, ready}, 16'd0);
    repeat (4 * DIV - 1) @(negedge clk);
    check_val("wrapload_busy1", {15'd0, ready}, 16'd0);
    @(negedge clk);
    check_val("wrapload_ready", {15'd0, ready}, 16'd1);
    push_scan(16'h9876, 4'b1001, 1'b0);
    capture_scan("wrapload");

    check_val("exp_q_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the clock cycles each digit is selected; legal range DIV >= 4.
REQ-002 Parameter GAP, default 1000, SHALL set the dead-time cycles at the start of each digit slot, with all anodes off; legal range 1 <= GAP < DIV.
REQ-003 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 BTN  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 VALUE  in  16  SHALL carry the hex value to display; nibble i drives digit i, and digit 0 is the rightmost.
REQ-006 LOAD  in  1  SHALL be the request strobe; VALUE, DP_IN and BLANK_LZ are captured when LOAD=1 and READY=1.
REQ-007 READY  out  1  SHALL be high when a new value can be accepted.
REQ-008 DP_IN  in  4  SHALL give the decimal-point enable for each digit.
REQ-009 BLANK_LZ  in  1  SHALL enable leading-zero suppression.
REQ-010 SEG  out  7  SHALL drive the segments active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 DP_N  out  1  SHALL drive the decimal point active-low.
REQ-012 AN  out  4  SHALL drive the digit anodes active-low; AN[i] selects digit i.

Function
REQ-013 A slot counter SHALL count 0..DIV-1 and wrap to 0; at each wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-014 While counter < GAP, the block SHALL drive AN=4'hF; otherwise AN SHALL be all ones except bit [index]=0.
REQ-015 SEG, DP_N and AN SHALL be registered, lagging the counter/index state by exactly one cycle.
REQ-016 An accepted LOAD SHALL write a pending register and drive READY=0 from the next cycle.
REQ-017 The pending value SHALL move to the display register only on the wrap from index 3 to index 0; READY SHALL return to 1 in the cycle after that transfer, so no scan ever mixes old and new digits.
REQ-018 LOAD while READY=0 SHALL be ignored, with no effect on the pending or display registers.
REQ-019 LOAD with READY=1 on the same cycle as a 3->0 wrap SHALL be captured as pending and applied at the following 3->0 wrap.
REQ-020 The hex decode SHALL produce, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-021 With BLANK_LZ=1, digit i (i=3..1) SHALL be blanked (SEG=7F) when nibble i and all higher nibbles are 0; digit 0 SHALL never be blanked.
REQ-022 DP_N SHALL be the inverse of the displayed DP bit for the selected digit, and SHALL be 1 during dead time; blanking does not suppress DP.
REQ-023 Until the first transfer after reset, the display register SHALL hold value 0, DP 0 and BLANK_LZ 0.

Reset
REQ-024 While BTN=1, the block SHALL force counter=0, index=0, display and pending registers=0, pending-valid=0, READY=1, AN=4'hF, SEG=7'h7F and DP_N=1.
REQ-025 BTN asserted mid-scan or with an update pending SHALL discard the pending value; after BTN falls, the scan SHALL restart at digit 0 with dead time.

Structure
REQ-026 Shared package seg_pkg SHALL hold the digit count (4), the 16-entry hex-to-segment table, the SEG_OFF constant (7'h7F) and the AN_OFF constant (4'hF).
REQ-027 The combinational decoder SHALL be the sub-module hex7seg (4-bit in, 7-bit active-low out); the counter, index, handshake and output registers SHALL stay in seg_display_scanner.

Verification (DIV=8, GAP=2)
REQ-028 Reset: BTN=1 for 3 cycles -> AN=F, SEG=7F, DP_N=1, READY=1; after release, AN stays F for the first 2+1 cycles.
REQ-029 LOAD VALUE=16'h1234, DP_IN=0, LZ=0 -> READY=0 until the 3->0 wrap. The next scan SHALL then show:
  - AN=E / SEG=19
  - AN=D / SEG=30
  - AN=B / SEG=24
  - AN=7 / SEG=79
  - each digit selected for 6 of its 8 cycles
REQ-030 LOAD 16'h0050, LZ=1, DP_IN=4'b0010 -> digits 3 and 2 show SEG=7F; digit 1 shows SEG=12 with DP_N=0; digit 0 shows SEG=40.
REQ-031 LOAD 16'h0000, LZ=1 -> only digit 0 lights (SEG=40); digits 1-3 show SEG=7F with AN still cycling.
REQ-032 LOAD 16'hAAAA, then LOAD 16'hBBBB on the next cycle (READY=0) -> the display shows AAAA; BBBB is never displayed.
REQ-033 LOAD 16'hFFFF, then BTN pulse before the wrap -> after reset, all digits show 40 and READY=1.
